// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: state encoding, bit-timing derivation and counter width.
// The receiver imports the same package so both sides agree on timing.
package uart_tx_pkg;

    localparam int DATA_BITS = 8;
    localparam int CNT_W     = 16;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    function automatic int clocks_per_bit(input int clock_hz, input int baud);
        return clock_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
interface uart_tx_if;
    import uart_tx_pkg::*;

    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;

    modport master (output tx_valid, output tx_data, input  tx_ready);
    modport slave  (input  tx_valid, input  tx_data, output tx_ready);

endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLOCKS_PER_BIT-1 and pulses bit_done_o on the last count.
module uart_baud_counter
    import uart_tx_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clr_i,
    output logic bit_done_o
);

    localparam cnt_t LAST = cnt_t'(CLOCKS_PER_BIT - 1);

    cnt_t cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr_i || (cnt_q == LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + cnt_t'(1);
        end
    end

    assign bit_done_o = !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter with a one-entry holding register so the next byte
// can be queued during a frame and sent with no idle gap.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 100000000,
    parameter int BAUD_RATE       = 115200,
    parameter int STOP_BITS       = 1
) (
    input  logic     clock,
    input  logic     reset,
    uart_tx_if.slave tx,
    output logic     tx_busy,
    output logic     serial_tx
);

    localparam int   CPB       = clocks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
    localparam logic STOP_LAST = (STOP_BITS == 2);

    generate
        if (CPB < 2 || CPB > (1 << CNT_W) || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_cfg
            $error("uart_tx: unsupported CLOCKS_PER_BIT or STOP_BITS");
        end
    endgenerate

    uart_state_e          state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] hold_q;
    logic                 hold_full_q;
    logic                 tx_ready_q;
    logic                 busy_q;
    logic                 serial_q;
    logic [2:0]           bit_idx_q;
    logic                 stop_idx_q;

    logic bit_done;
    logic cnt_clr;
    logic accept;
    logic stop_end;
    logic load;
    logic hold_full_d;
    logic to_idle;
    logic busy_d;

    // Counter idles at zero so the first START cycle is count 0.
    assign cnt_clr = (state_q == IDLE);

    uart_baud_counter #(
        .CLOCKS_PER_BIT(CPB)
    ) u_baud (
        .clock      (clock),
        .reset      (reset),
        .clr_i      (cnt_clr),
        .bit_done_o (bit_done)
    );

    // Accept needs an empty holder and load needs a full one, so they never coincide.
    always_comb begin
        accept      = tx.tx_valid && tx_ready_q;
        stop_end    = (state_q == STOP) && bit_done && (stop_idx_q == STOP_LAST);
        load        = hold_full_q && ((state_q == IDLE) || stop_end);
        hold_full_d = accept || (hold_full_q && !load);
        to_idle     = !hold_full_q && ((state_q == IDLE) || stop_end);
        busy_d      = !to_idle || hold_full_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            serial_q    <= 1'b1;
            bit_idx_q   <= '0;
            stop_idx_q  <= 1'b0;
        end else begin
            hold_full_q <= hold_full_d;
            tx_ready_q  <= !hold_full_d;
            busy_q      <= busy_d;
            if (accept) begin
                hold_q <= tx.tx_data;
            end

            if (load) begin
                shift_q  <= hold_q;
                serial_q <= 1'b0;
                state_q  <= START;
            end else begin
                case (state_q)
                    IDLE: begin
                        serial_q <= 1'b1;
                    end
                    START: begin
                        if (bit_done) begin
                            serial_q  <= shift_q[0];
                            bit_idx_q <= '0;
                            state_q   <= DATA;
                        end
                    end
                    DATA: begin
                        if (bit_done) begin
                            if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                                serial_q   <= 1'b1;
                                stop_idx_q <= 1'b0;
                                state_q    <= STOP;
                            end else begin
                                shift_q   <= {1'b0, shift_q[DATA_BITS-1:1]};
                                serial_q  <= shift_q[1];
                                bit_idx_q <= bit_idx_q + 3'd1;
                            end
                        end
                    end
                    STOP: begin
                        if (stop_end) begin
                            state_q <= IDLE;
                        end else if (bit_done) begin
                            stop_idx_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q  <= IDLE;
                        serial_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign tx.tx_ready = tx_ready_q;
    assign tx_busy     = busy_q;
    assign serial_tx   = serial_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 16 clocks per bit, one- and two-stop-bit instances.
module tb_uart_tx;

    logic clock;
    logic reset;
    logic busy1, busy2, ser1, ser2;
    int   n_checks = 0;
    int   n_fail   = 0;

    uart_tx_if ifc1 ();
    uart_tx_if ifc2 ();

    uart_tx #(.CLOCK_FREQUENCY(1600), .BAUD_RATE(100), .STOP_BITS(1)) dut1 (
        .clock(clock), .reset(reset), .tx(ifc1.slave), .tx_busy(busy1), .serial_tx(ser1));
    uart_tx #(.CLOCK_FREQUENCY(1600), .BAUD_RATE(100), .STOP_BITS(2)) dut2 (
        .clock(clock), .reset(reset), .tx(ifc2.slave), .tx_busy(busy2), .serial_tx(ser2));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic line(input int which);
        return (which == 1) ? ser1 : ser2;
    endfunction

    function automatic logic bsy(input int which);
        return (which == 1) ? busy1 : busy2;
    endfunction

    function automatic logic rdy(input int which);
        return (which == 1) ? ifc1.tx_ready : ifc2.tx_ready;
    endfunction

    // Offer d until accepted; rwait = negedges spent with tx_ready low. Called and returns at a negedge.
    task automatic send(input int which, input logic [7:0] d, input bit keep, output int rwait);
        rwait = -1;
        if (which == 1) begin ifc1.tx_valid = 1'b1; ifc1.tx_data = d; end
        else            begin ifc2.tx_valid = 1'b1; ifc2.tx_data = d; end
        for (int k = 0; k < 1000; k++) begin
            if (rdy(which) === 1'b1) begin rwait = k; break; end
            @(negedge clock);
        end
        @(negedge clock);
        if (!keep) begin
            if (which == 1) begin ifc1.tx_valid = 1'b0; ifc1.tx_data = ~d; end
            else            begin ifc2.tx_valid = 1'b0; ifc2.tx_data = ~d; end
        end
    endtask

    // Bench receiver: waits for a start bit, then samples every cycle of the frame.
    task automatic capture(input int which, input int nstop, output logic [7:0] b,
                           output int wait_c, output int bad, output int busy_c);
        logic v, first;
        b = '0; bad = 0; busy_c = 0; wait_c = -1; first = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            if (line(which) === 1'b0) begin wait_c = k; break; end
            @(negedge clock);
        end
        if (wait_c < 0) return;
        for (int bn = 0; bn < 9 + nstop; bn++) begin
            for (int c = 0; c < 16; c++) begin
                v = line(which);
                if (bsy(which) === 1'b1) busy_c++;
                if (c == 0) begin
                    first = v;
                    if (bn == 0 && v !== 1'b0) bad++;
                    else if (bn >= 1 && bn <= 8) b[bn-1] = v;
                    else if (bn > 8 && v !== 1'b1) bad++;
                end else if (v !== first) begin
                    bad++;
                end
                @(negedge clock);
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        ifc1.tx_valid = 1'b0; ifc1.tx_data = '0;
        ifc2.tx_valid = 1'b0; ifc2.tx_data = '0;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++; if (ser1 !== 1'b1)          begin n_fail++; $display("FAIL reset_serial got %b want 1", ser1); end
        n_checks++; if (ifc1.tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ifc1.tx_ready); end
        n_checks++; if (busy1 !== 1'b0)         begin n_fail++; $display("FAIL reset_busy got %b want 0", busy1); end
        reset = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clock);
            if (ser1 !== 1'b1 || ifc1.tx_ready !== 1'b1 || busy1 !== 1'b0 ||
                ser2 !== 1'b1 || ifc2.tx_ready !== 1'b1 || busy2 !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL idle_100 bad cycles got %0d want 0", bad); end
    endtask

    task automatic test_single();
        logic [7:0] b; int w, wt, bad, bc;
        send(1, 8'hA5, 1'b0, w);
        n_checks++; if (ifc1.tx_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready_after_accept got %b want 0", ifc1.tx_ready); end
        n_checks++; if (busy1 !== 1'b1)         begin n_fail++; $display("FAIL single_busy_after_accept got %b want 1", busy1); end
        capture(1, 1, b, wt, bad, bc);
        n_checks++; if (wt !== 1)       begin n_fail++; $display("FAIL single_start_latency got %0d want 1", wt); end
        n_checks++; if (b !== 8'hA5)    begin n_fail++; $display("FAIL single_data got %h want a5", b); end
        n_checks++; if (bad !== 0)      begin n_fail++; $display("FAIL single_frame_shape got %0d want 0", bad); end
        n_checks++; if (bc !== 160)     begin n_fail++; $display("FAIL single_busy_cycles got %0d want 160", bc); end
        n_checks++; if (busy1 !== 1'b0 || ser1 !== 1'b1 || ifc1.tx_ready !== 1'b1)
            begin n_fail++; $display("FAIL single_back_idle got busy=%b ser=%b rdy=%b want 0 1 1", busy1, ser1, ifc1.tx_ready); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b0, b1; int w0, w1, wt0, wt1, bad0, bad1, bc0, bc1;
        fork
            begin send(1, 8'h00, 1'b0, w0); send(1, 8'hFF, 1'b0, w1); end
            begin capture(1, 1, b0, wt0, bad0, bc0); capture(1, 1, b1, wt1, bad1, bc1); end
        join
        n_checks++; if (w1 !== 1)             begin n_fail++; $display("FAIL b2b_ready_low_cycles got %0d want 1", w1); end
        n_checks++; if (b0 !== 8'h00 || b1 !== 8'hFF) begin n_fail++; $display("FAIL b2b_data got %h %h want 00 ff", b0, b1); end
        n_checks++; if (wt1 !== 0)            begin n_fail++; $display("FAIL b2b_gap got %0d want 0", wt1); end
        n_checks++; if (bad0 !== 0 || bad1 !== 0) begin n_fail++; $display("FAIL b2b_frame_shape got %0d %0d want 0 0", bad0, bad1); end
        n_checks++; if (busy1 !== 1'b0)       begin n_fail++; $display("FAIL b2b_busy_end got %b want 0", busy1); end
    endtask

    task automatic test_backpressure();
        logic [7:0] b0, b1, b2; int w0, w1, w2, t0, t1, t2, e0, e1, e2, c0, c1, c2, extra;
        fork
            begin send(1, 8'h11, 1'b1, w0); send(1, 8'h22, 1'b1, w1); send(1, 8'h33, 1'b0, w2); end
            begin capture(1, 1, b0, t0, e0, c0); capture(1, 1, b1, t1, e1, c1); capture(1, 1, b2, t2, e2, c2); end
        join
        n_checks++; if (w0 !== 0 || w1 !== 1 || w2 !== 159)
            begin n_fail++; $display("FAIL bp_accept_waits got %0d %0d %0d want 0 1 159", w0, w1, w2); end
        n_checks++; if (b0 !== 8'h11 || b1 !== 8'h22 || b2 !== 8'h33)
            begin n_fail++; $display("FAIL bp_order got %h %h %h want 11 22 33", b0, b1, b2); end
        n_checks++; if (t1 !== 0 || t2 !== 0 || e0 !== 0 || e1 !== 0 || e2 !== 0)
            begin n_fail++; $display("FAIL bp_frames got gaps %0d %0d errs %0d %0d %0d want 0", t1, t2, e0, e1, e2); end
        extra = 0;
        repeat (40) begin
            if (ser1 !== 1'b1 || busy1 !== 1'b0) extra++;
            @(negedge clock);
        end
        n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL bp_no_duplicate got %0d want 0", extra); end
    endtask

    task automatic test_two_stop();
        logic [7:0] b; int w, wt, bad, bc;
        send(2, 8'h80, 1'b0, w);
        capture(2, 2, b, wt, bad, bc);
        n_checks++; if (wt !== 1)      begin n_fail++; $display("FAIL stop2_latency got %0d want 1", wt); end
        n_checks++; if (b !== 8'h80)   begin n_fail++; $display("FAIL stop2_data got %h want 80", b); end
        n_checks++; if (bad !== 0)     begin n_fail++; $display("FAIL stop2_frame_shape got %0d want 0", bad); end
        n_checks++; if (bc !== 176)    begin n_fail++; $display("FAIL stop2_busy_cycles got %0d want 176", bc); end
        n_checks++; if (busy2 !== 1'b0 || ser2 !== 1'b1)
            begin n_fail++; $display("FAIL stop2_back_idle got busy=%b ser=%b want 0 1", busy2, ser2); end
    endtask

    task automatic test_mid_reset();
        int w0, w1, bad;
        send(1, 8'h3C, 1'b0, w0);
        send(1, 8'h55, 1'b0, w1);
        repeat (70) @(negedge clock);
        n_checks++; if (ifc1.tx_ready !== 1'b0 || ser1 !== 1'b1)
            begin n_fail++; $display("FAIL midrst_pre got rdy=%b ser=%b want 0 1", ifc1.tx_ready, ser1); end
        #2 reset = 1'b0;
        #1;
        n_checks++; if (ser1 !== 1'b1 || ifc1.tx_ready !== 1'b1 || busy1 !== 1'b0)
            begin n_fail++; $display("FAIL midrst_async got ser=%b rdy=%b busy=%b want 1 1 0", ser1, ifc1.tx_ready, busy1); end
        @(negedge clock);
        reset = 1'b1;
        bad = 0;
        repeat (200) begin
            @(negedge clock);
            if (ser1 !== 1'b1 || busy1 !== 1'b0 || ifc1.tx_ready !== 1'b1) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL midrst_dropped got %0d bad cycles want 0", bad); end
    endtask

    initial begin
        reset = 1'b0;
        @(negedge clock);
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_two_stop();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout after %0d checks", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
